// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog_if
// Description : Control and status bundle for the programmable clock divider.
//               The master drives enable/clear/load/divisor; the slave returns
//               the square wave, tick strobe and debug observability.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
   parameter int WIDTH = 17
);
   logic             en;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] div_val;
   logic             clk_out;
   logic             tick;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] div_cur;

   modport master (
      output en, clear, load, div_val,
      input  clk_out, tick, count, div_cur
   );

   modport slave (
      input  en, clear, load, div_val,
      output clk_out, tick, count, div_cur
   );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Programmable clock-enable / divided-clock generator. A single
//               counter runs against a run-time divisor N, giving a one-cycle
//               tick every N enabled cycles and a square wave of period 2N.
//               New divisors are held pending and applied only at a period
//               boundary (terminal count or clear), so no runt pulses occur.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
   parameter int WIDTH     = 17,
   parameter int DIV_RESET = 2**16
) (
   input  wire logic      clk,
   input  wire logic      reset,   // asynchronous, active-low
   clk_div_prog_if.slave  bus
);

   localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RESET);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q,  cnt_d;
   logic [WIDTH-1:0] div_q,  div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pvld_q, pvld_d;
   logic             sq_q,   sq_d;
   logic             tick_q, tick_d;

   logic             w_running;
   logic             w_term;
   logic [WIDTH-1:0] w_next_div;

   assign w_running  = bus.en && (div_q != '0);
   assign w_term     = w_running && (cnt_q == div_q - ONE);
   // Divisor to adopt at a boundary: a same-cycle load beats the pending one.
   assign w_next_div = bus.load ? bus.div_val : (pvld_q ? pend_q : div_q);

   // Next-state: clear beats terminal count beats plain counting.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pend_d = pend_q;
      pvld_d = pvld_q;
      sq_d   = sq_q;
      tick_d = 1'b0;
      if (bus.clear) begin
         cnt_d  = '0;
         sq_d   = 1'b0;
         div_d  = w_next_div;
         pend_d = bus.load ? bus.div_val : pend_q;
         pvld_d = 1'b0;
      end else if (w_term) begin
         cnt_d  = '0;
         sq_d   = ~sq_q;
         tick_d = 1'b1;
         div_d  = w_next_div;
         pend_d = bus.load ? bus.div_val : pend_q;
         pvld_d = 1'b0;
      end else begin
         if (w_running) begin
            cnt_d = cnt_q + ONE;
         end
         if (bus.load) begin
            // A stopped divider has no boundary coming, so restart at once.
            if ((div_q == '0) && (bus.div_val != '0)) begin
               div_d  = bus.div_val;
               cnt_d  = '0;
               pend_d = bus.div_val;
               pvld_d = 1'b0;
            end else begin
               pend_d = bus.div_val;
               pvld_d = 1'b1;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         div_q  <= DIV_INIT;
         pend_q <= DIV_INIT;
         pvld_q <= 1'b0;
         sq_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         pend_q <= pend_d;
         pvld_q <= pvld_d;
         sq_q   <= sq_d;
         tick_q <= tick_d;
      end
   end

   assign bus.clk_out = sq_q;
   assign bus.tick    = tick_q;
   assign bus.count   = cnt_q;
   assign bus.div_cur = div_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Self-checking bench for clk_div_prog. A behavioural model
//               tracks the divider; loads waiting for a boundary are kept in
//               a queue whose last entry wins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

   localparam int WIDTH     = 17;
   localparam int DIV_RESET = 65536;

   logic clk;
   logic reset;

   clk_div_prog_if #(.WIDTH(WIDTH)) bus ();

   clk_div_prog #(.WIDTH(WIDTH), .DIV_RESET(DIV_RESET)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   int unsigned m_cnt, m_div, m_sq, m_tick;
   int unsigned pq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_div = DIV_RESET; m_sq = 0; m_tick = 0;
      pq.delete();
   endtask

   // One rising edge of the reference model, from the inputs seen at that edge.
   task automatic model_edge(input bit en, input bit clr, input bit ld, input int unsigned dv);
      int unsigned boundary_div;
      bit term;
      term = en && (m_div != 0) && (m_cnt == m_div - 1);
      boundary_div = ld ? dv : ((pq.size() != 0) ? pq[$] : m_div);
      if (clr) begin
         m_cnt = 0; m_sq = 0; m_tick = 0; m_div = boundary_div;
         pq.delete();
      end else if (term) begin
         m_cnt = 0; m_sq = 1 - m_sq; m_tick = 1; m_div = boundary_div;
         pq.delete();
      end else begin
         m_tick = 0;
         if (en && m_div != 0) m_cnt = m_cnt + 1;
         if (ld) begin
            if (m_div == 0 && dv != 0) begin
               m_div = dv; m_cnt = 0;
               pq.delete();
            end else begin
               pq.push_back(dv);
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_count"}, 32'(bus.count),   m_cnt);
      chk({tag, "_tick"},  32'(bus.tick),    m_tick);
      chk({tag, "_clkout"},32'(bus.clk_out), m_sq);
      chk({tag, "_divcur"},32'(bus.div_cur), m_div);
   endtask

   // Drive inputs, take one edge, update the model and compare 1 ns later.
   task automatic step(input bit en, input bit clr, input bit ld, input int unsigned dv,
                       input string tag);
      bus.en = en; bus.clear = clr; bus.load = ld; bus.div_val = WIDTH'(dv);
      @(posedge clk);
      model_edge(en, clr, ld, dv);
      #1;
      check_all(tag);
   endtask

   initial begin
      int first, nt, rise;
      bit sq5, sq10;
      bit r_en, r_clr, r_ld;
      int unsigned r_dv;

      reset = 1'b0;
      bus.en = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.div_val = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b1;

      // T6: run part of a default period, then assert reset between edges
      for (int i = 0; i < 300; i++) step(1, 0, 0, 0, "pre6");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("t6_async");
      repeat (2) @(posedge clk);
      #1;
      check_all("t6_held");
      reset = 1'b1;
      rise = 0;
      for (int i = 1; i <= 65536; i++) begin
         step(1, 0, 0, 0, "t6");
         if (rise == 0 && bus.clk_out === 1'b1) rise = i;
      end
      chk("t6_first_rise", rise, 65536);

      // T1: load 5 then clear; ticks at 5,10,15,20
      step(1, 0, 1, 5, "t1_ld");
      step(1, 1, 0, 0, "t1_clr");
      chk("t1_divcur", 32'(bus.div_cur), 5);
      first = 0; nt = 0; sq5 = 0; sq10 = 1;
      for (int i = 1; i <= 20; i++) begin
         step(1, 0, 0, 0, "t1");
         if (bus.tick === 1'b1) begin
            nt++;
            if (first == 0) first = i;
         end
         if (i == 5)  sq5  = bus.clk_out;
         if (i == 10) sq10 = bus.clk_out;
      end
      chk("t1_first_tick", first, 5);
      chk("t1_ticks", nt, 4);
      chk("t1_sq_hi", 32'(sq5), 1);
      chk("t1_sq_lo", 32'(sq10), 0);

      // T2: N=4 running, load 7 at cnt=1
      step(1, 1, 1, 4, "t2_clr");
      step(1, 0, 0, 0, "t2");
      step(1, 0, 1, 7, "t2_ld");
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1, 0, 0, 0, "t2");
         if (first == 0 && bus.tick === 1'b1) first = i;
      end
      chk("t2_first_tick", first, 2);

      // T3: N=6, freeze at cnt=3 for 3 cycles
      step(1, 1, 1, 6, "t3_clr");
      repeat (3) step(1, 0, 0, 0, "t3");
      repeat (3) step(0, 0, 0, 0, "t3_frz");
      chk("t3_hold", 32'(bus.count), 3);
      first = 0;
      for (int i = 1; i <= 6; i++) begin
         step(1, 0, 0, 0, "t3");
         if (first == 0 && bus.tick === 1'b1) first = i;
      end
      chk("t3_tick_after", first, 3);

      // T4: N=1, then N=0 (stop), then load 3 while stopped
      step(1, 1, 1, 1, "t4_clr");
      repeat (6) step(1, 0, 0, 0, "t4_n1");
      step(1, 0, 1, 0, "t4_ld0");
      repeat (6) step(1, 0, 0, 0, "t4_n0");
      chk("t4_stopped", 32'(bus.div_cur), 0);
      step(1, 0, 1, 3, "t4_ld3");
      chk("t4_restart", 32'(bus.div_cur), 3);
      first = 0;
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0, 0, "t4_n3");
         if (first == 0 && bus.tick === 1'b1) first = i;
      end
      chk("t4_tick3", first, 3);

      // T5: clear coinciding with terminal count, then clear+load 9
      step(1, 1, 1, 3, "t5_clr");
      repeat (2) step(1, 0, 0, 0, "t5");
      step(1, 1, 0, 0, "t5_clr_term");
      chk("t5_no_tick", 32'(bus.tick), 0);
      step(1, 1, 1, 9, "t5_clr_ld");
      chk("t5_div9", 32'(bus.div_cur), 9);
      repeat (12) step(1, 0, 0, 0, "t5");

      // Randomised traffic, including the maximum divisor
      for (int i = 0; i < 3000; i++) begin
         r_en  = ($urandom_range(0, 9) != 0);
         r_clr = ($urandom_range(0, 39) == 0);
         r_ld  = ($urandom_range(0, 19) == 0);
         r_dv  = ($urandom_range(0, 15) == 0) ? 32'h1FFFF : $urandom_range(0, 9);
         step(r_en, r_clr, r_ld, r_dv, "rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
